serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor, computes a - b one bit per clock, LSB first.
- The bit cell chains a borrow-in through two half-subtractor stages to form a full-subtractor cell; the cell's borrow-out feeds a registered borrow flip-flop.
- This is the sequential stage directly downstream of the half subtractor, consuming its diff/borrow outputs.
- Uses a start/done handshake so a controller can issue one subtraction at a time.

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_if.sv | 27 ++
 rtl/full_sub.sv | 34 +++
 rtl/half_sub.sv | 15 +
 rtl/serial_subtractor.sv | 96 +++++++++
 tb/tb_serial_subtractor.sv | 205 ++++++++++++++++++++
 6 files changed

// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_subtractor_pkg : shared state encoding and default operand width
// Revision: 1.0
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_subtractor_if : start/done request and result bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface
`default_nettype wire

// File: rtl/full_sub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// full_sub : one-bit full subtractor built from two half subtractors
// Revision: 1.0
// ---------------------------------------------------------------------------
module full_sub (
  input  wire logic a,
  input  wire logic b,
  input  wire logic bin,
  output logic      diff,
  output logic      bout
);
  logic d1;
  logic b1;
  logic b2;

  half_sub u_hs_ab (
    .a      (a),
    .b      (b),
    .diff   (d1),
    .borrow (b1)
  );

  // Second stage subtracts the incoming borrow from the partial difference.
  half_sub u_hs_bin (
    .a      (d1),
    .b      (bin),
    .diff   (diff),
    .borrow (b2)
  );

  assign bout = b1 | b2;
endmodule
`default_nettype wire

// File: rtl/half_sub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// half_sub : one-bit half subtractor (a - b)
// Revision: 1.0
// ---------------------------------------------------------------------------
module half_sub (
  input  wire logic a,
  input  wire logic b,
  output logic      diff,
  output logic      borrow
);
  assign diff   = a ^ b;
  assign borrow = ~a & b;
endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_subtractor : bit-serial a - b, LSB first, with start/done handshake
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic           clk,
  input  wire logic           rst,
  serial_subtractor_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic             bq;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic             d;
  logic             bout;
  logic [WIDTH-1:0] sr_next;

  full_sub u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (bq),
    .diff (d),
    .bout (bout)
  );

  assign sr_next = {d, sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      cnt      <= '0;
      bq       <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new request exactly like IDLE, enabling back-to-back ops.
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            sr     <= '0;
            bq     <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= S_SHIFT;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_SHIFT: begin
          sr  <= sr_next;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          bq  <= bout;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff_q   <= sr_next;
            borrow_q <= bout;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_subtractor : randomized check against a cycle-count arithmetic model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic fs_a, fs_b, fs_bin, fs_diff, fs_bout;
  full_sub u_fs (
    .a    (fs_a),
    .b    (fs_b),
    .bin  (fs_bin),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request yields (a-b) exactly W edges after acceptance.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic         m_bor  = 1'b0;
  logic [W:0]   m_pend = '0;
  int           m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_diff = '0; m_bor = 1'b0; m_left = 0;
    end else if (!m_busy && bus.start) begin
      m_pend = {1'b0, bus.a} - {1'b0, bus.b};
      m_busy = 1'b1; m_done = 1'b0; m_left = W;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_diff = m_pend[W-1:0]; m_bor = m_pend[W];
      end
    end else begin
      m_done = 1'b0;
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("done", 32'(bus.done), 32'(m_done));
      check("diff", 32'(bus.diff), 32'(m_diff));
      check("borrow_out", 32'(bus.borrow_out), 32'(m_bor));
      if (bus.done === 1'b1) done_seen++;
    end
  end

  // Caller sits at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    bus.start = 1'b1; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.busy === 1'b1) busy_cyc++;
    end
    if (cyc >= 40) check("done_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic op_literal(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] ed, input logic eb);
    int cyc, bc;
    start_op(av, bv);
    wait_done(cyc, bc);
    check("lat", 32'(cyc), 32'(W));
    check("busy_cycles", 32'(bc), 32'(W));
    check("lit_diff", 32'(bus.diff), 32'(ed));
    check("lit_borrow", 32'(bus.borrow_out), 32'(eb));
    @(negedge clk);
    check("done_drop", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int cyc, bc, d0;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;

    for (int v = 0; v < 8; v++) begin
      logic [2:0] vec;
      int x, y, z;
      vec = 3'(v);
      fs_a = vec[2]; fs_b = vec[1]; fs_bin = vec[0];
      x = int'(vec[2]); y = int'(vec[1]); z = int'(vec[0]);
      #1;
      check("fs_diff", 32'(fs_diff), 32'((x - y - z) & 1));
      check("fs_bout", 32'(fs_bout), 32'((x < y + z) ? 1 : 0));
    end

    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op_literal(8'd5,  8'd3,  8'h02, 1'b0);
    op_literal(8'h03, 8'h05, 8'hFE, 1'b1);
    op_literal(8'h00, 8'hFF, 8'h01, 1'b1);
    op_literal(8'hA5, 8'hA5, 8'h00, 1'b0);
    op_literal(8'hFF, 8'h01, 8'hFE, 1'b0);

    // Start while busy is ignored; then back-to-back from the DONE cycle.
    #1 d0 = done_seen;
    start_op(8'd5, 8'd3);
    @(negedge clk); @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, bc);
    check("ign_diff", 32'(bus.diff), 32'h02);
    #1 check("ign_one_done", 32'(done_seen - d0), 32'd1);
    start_op(8'd9, 8'd1);
    wait_done(cyc, bc);
    check("b2b_gap", 32'(cyc + 1), 32'(W + 1));
    check("b2b_diff", 32'(bus.diff), 32'h08);
    #1 check("b2b_two_done", 32'(done_seen - d0), 32'd2);
    @(negedge clk);

    // Reset mid-operation.
    start_op(8'hF0, 8'h0F);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_diff", 32'(bus.diff), 32'd0);
    check("mid_rst_bor", 32'(bus.borrow_out), 32'd0);
    #1 d0 = done_seen;
    repeat (12) @(negedge clk);
    #1 check("mid_rst_no_done", 32'(done_seen - d0), 32'd0);
    @(negedge clk);
    op_literal(8'd5, 8'd3, 8'h02, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int gap;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      start_op(ra, rb);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        bus.start = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
      end
      wait_done(cyc, bc);
      check("rnd_diff", 32'(bus.diff), 32'(W'(ra - rb)));
      check("rnd_borrow", 32'(bus.borrow_out), 32'(ra < rb));
    end

    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
